// File: rtl/alu_mdu.sv
// EX-stage integer ALU (combinational, full MIPS op set) plus a fixed-latency
// multiply/divide unit that owns the HI/LO registers.
module alu_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] alu_out,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW     = $clog2(WIDTH);
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_OR   = 4'd2,  ALU_AND  = 4'd3,
    ALU_XOR  = 4'd4,  ALU_NOR  = 4'd5,  ALU_SLT  = 4'd6,  ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,  ALU_SRL  = 4'd9,  ALU_SRA  = 4'd10, ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NONE = 3'd0, MD_MULT = 3'd1, MD_MULTU = 3'd2, MD_DIV = 3'd3,
    MD_DIVU = 3'd4, MD_MTHI = 3'd5, MD_MTLO = 3'd6, MD_RSVD = 3'd7
  } md_op_e;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic        [SHW-1:0]   shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = a[SHW-1:0];

  always_comb begin
    alu_out = '0;
    case (alu_op)
      ALU_ADD:  alu_out = a + b;
      ALU_SUB:  alu_out = a - b;
      ALU_OR:   alu_out = a | b;
      ALU_AND:  alu_out = a & b;
      ALU_XOR:  alu_out = a ^ b;
      ALU_NOR:  alu_out = ~(a | b);
      ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:  alu_out = b << shamt;
      ALU_SRL:  alu_out = b >> shamt;
      ALU_SRA:  alu_out = b_s >>> shamt;
      ALU_LUI:  alu_out = b << (WIDTH / 2);
      default:  alu_out = '0;
    endcase
  end

  // Signed divide with the divide-by-zero and MOST_NEG/-1 overflow cases
  // pinned to their architectural results; returns {remainder, quotient}.
  function automatic logic [2*WIDTH-1:0] div_signed(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] xd;
    logic signed [WIDTH-1:0] yd;
    logic signed [WIDTH-1:0] quo;
    logic signed [WIDTH-1:0] rem;
    xd  = x;
    yd  = y;
    quo = '0;
    rem = '0;
    if (y == '0) begin
      quo = '1;
      rem = xd;
    end else if ((x == MOST_NEG) && (y == '1)) begin
      quo = MOST_NEG;
      rem = '0;
    end else begin
      quo = xd / yd;
      rem = xd % yd;
    end
    return {rem, quo};
  endfunction

  function automatic logic [2*WIDTH-1:0] div_unsigned(input logic [WIDTH-1:0] x,
                                                      input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    if (y == '0) begin
      quo = '1;
      rem = x;
    end else begin
      quo = x / y;
      rem = x % y;
    end
    return {rem, quo};
  endfunction

  function automatic logic [2*WIDTH-1:0] md_compute(input md_op_e op,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
    logic signed [2*WIDTH-1:0] xs;
    logic signed [2*WIDTH-1:0] ys;
    logic        [2*WIDTH-1:0] xu;
    logic        [2*WIDTH-1:0] yu;
    logic        [2*WIDTH-1:0] res;
    xs  = {{WIDTH{x[WIDTH-1]}}, x};
    ys  = {{WIDTH{y[WIDTH-1]}}, y};
    xu  = {{WIDTH{1'b0}}, x};
    yu  = {{WIDTH{1'b0}}, y};
    res = '0;
    case (op)
      MD_MULT:  res = xs * ys;
      MD_MULTU: res = xu * yu;
      MD_DIV:   res = div_signed(x, y);
      MD_DIVU:  res = div_unsigned(x, y);
      default:  res = '0;
    endcase
    return res;
  endfunction

  md_op_e             op_p0;
  logic [WIDTH-1:0]   a_p0;
  logic [WIDTH-1:0]   b_p0;
  logic [CNT_W-1:0]   cnt_p0;
  logic [2*WIDTH-1:0] md_res;
  logic               accept;

  assign busy   = (cnt_p0 != '0);
  assign accept = md_start && !busy && (md_op != MD_NONE) && (md_op != MD_RSVD);
  assign md_res = md_compute(op_p0, a_p0, b_p0);

  // Stage p0: operands captured at accept; HI/LO written as the count expires
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_p0  <= MD_NONE;
      a_p0   <= '0;
      b_p0   <= '0;
      cnt_p0 <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      case (md_op)
        MD_MTHI: hi <= a;
        MD_MTLO: lo <= a;
        MD_MULT, MD_MULTU: begin
          op_p0  <= md_op_e'(md_op);
          a_p0   <= a;
          b_p0   <= b;
          cnt_p0 <= CNT_W'(MULT_CYCLES);
        end
        default: begin
          op_p0  <= md_op_e'(md_op);
          a_p0   <= a;
          b_p0   <= b;
          cnt_p0 <= CNT_W'(DIV_CYCLES);
        end
      endcase
    end else if (busy) begin
      cnt_p0 <= cnt_p0 - CNT_W'(1);
      if (cnt_p0 == CNT_W'(1)) begin
        hi <= md_res[2*WIDTH-1:WIDTH];
        lo <= md_res[WIDTH-1:0];
      end
    end
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the pipeline's 3-op integer ALU, sitting in the EX stage.
- Combinational ALU path is widened to the full MIPS integer op set and made width-generic.
- Adds a sequential multiply/divide unit (MDU) with HI/LO registers, fixed multi-cycle latency and a busy flag.
- Hazard logic uses the busy flag to stall mult/div/mfhi/mflo/mthi/mtlo in the decode stage.

Parameters:
- WIDTH, 32, datapath width; must be a power of two and ≥ 8.
- MULT_CYCLES, 5, busy cycles for mult/multu; ≥ 1.
- DIV_CYCLES, 10, busy cycles for div/divu; ≥ 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_op  in  4  ALU operation select (encodings below).
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt or extended immediate).
- alu_out  out  WIDTH  combinational ALU result.
- md_op  in  3  MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- md_start  in  1  one-cycle MDU request qualifier.
- busy  out  1  MDU computing.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- ALU encodings, all combinational:
  - 0 add: a+b, wraps modulo 2^WIDTH, no overflow trap.
  - 1 sub: a−b.
  - 2 or.
  - 3 and.
  - 4 xor.
  - 5 nor.
  - 6 slt: signed compare, result 1 or 0, zero-extended.
  - 7 sltu: unsigned compare, result 1 or 0, zero-extended.
  - 8 sll: b << a[log2(WIDTH)−1:0].
  - 9 srl: logical right shift, same shift-amount rule.
  - 10 sra: arithmetic right shift, same shift-amount rule.
  - 11 lui: b << WIDTH/2.
  - 12–15: drive 0. Never x.
- Reset (reset=0, asynchronous):
  - hi=0, lo=0, busy=0, counter=0, captured operands=0.
  - Takes effect immediately. An in-flight operation is aborted and produces no HI/LO write after release.
- Accept condition: a request is accepted on a rising edge only when md_start=1, busy=0 and md_op is 1–6.
  - md_op 0 or 7 with md_start=1: no effect.
- mthi/mtlo:
  - On the accepting edge, hi←a (mthi) or lo←a (mtlo).
  - busy stays 0; new value is visible the next cycle.
- mult/multu/div/divu on the accepting edge:
  - Capture a, b and the op into internal registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES; busy=1 from the next cycle.
  - Counter decrements each edge while nonzero; busy = (counter≠0).
  - On the edge where the counter goes 1→0, write HI/LO and deassert busy together.
  - Accepted at edge k: busy high for exactly N cycles; HI/LO valid at edge k+N.
- Results:
  - mult: signed 2·WIDTH product; hi=upper half, lo=lower half.
  - multu: same, unsigned.
  - div: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - divu: same, unsigned.
  - Computed only from the captured operands; a/b changes while busy have no effect.
- Divide by zero, both div and divu: lo=all ones, hi=dividend. Busy timing is unchanged.
- Signed overflow (div of most-negative value by −1): lo=most-negative value, hi=0.
- Any md_start while busy=1 is ignored entirely, including mthi/mtlo. The pipeline guarantees a stall, but the block must not corrupt state if one slips through.
- hi and lo are outputs of HI/LO registers only; no bypass of in-flight results.
- The ALU path is independent of MDU state and usable every cycle, including while busy.

Test Plan:
1. ALU sweep, WIDTH=32:
   - add 0x7FFFFFFF+1 → 0x80000000.
   - sub 0−1 → 0xFFFFFFFF.
   - slt a=0xFFFFFFFF, b=1 → 1; sltu with the same operands → 0.
   - sra b=0x80000000, a=4 → 0xF8000000.
   - lui b=0x1234 → 0x12340000.
   - alu_op=13 → 0.
2. mult a=−3, b=7:
   - busy high exactly 5 cycles after the accepting edge.
   - Then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
   - multu a=0xFFFFFFFF, b=2 → hi=1, lo=0xFFFFFFFE.
3. div a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles. Change a/b during busy → result unchanged.
4. divu a=5, b=0 → lo=0xFFFFFFFF, hi=5. div a=0x80000000, b=−1 → lo=0x80000000, hi=0.
5. Start mult, then pulse md_start with mtlo a=0xAA at busy cycle 2 → ignored; final lo=product. Then mthi a=0x55 → hi=0x55 next cycle, busy stays 0.
6. Start div; assert reset low mid-cycle at busy cycle 4 → busy, hi, lo go 0 immediately, before the next clock. After release, no late HI/LO write occurs.
